return_stack_module: RTL and testbench
======================================

Name: return_stack_module

Overview:
Hardware return-address stack that feeds the stack_in input of the program-counter stage.
- On a subroutine call (BSR), the return address is pushed.
- On RET, it is popped; the top entry is always presented so the PC stage can load it on the same edge as the pop.
- Sits between the instruction decoder (issues push/pop strobes) and the PC stage (consumes top).

Parameters:
ADDR_W, 11, width of stored return addresses (matches PC width)
DEPTH, 8, number of stack entries; power of two, >= 2
CNT_W, 4, width of count output; must satisfy 2^CNT_W > DEPTH

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
push  input  1  decoder BSR strobe; push push_addr this cycle
pop  input  1  decoder RET strobe; discard top entry this cycle
push_addr  input  ADDR_W  return address to store (PC + 1 of the BSR)
top  output  ADDR_W  current top-of-stack value; drives PC stage stack_in
count  output  CNT_W  number of valid entries, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Storage: DEPTH x ADDR_W register array, write pointer wp (log2 DEPTH bits) and count. Top entry is mem[wp-1] modulo DEPTH.
- top is combinational from the array and pointer. It reflects the state after the most recent edge (zero added latency), so a RET pop and the PC load on the same edge see the pre-pop top.
- top = 0 whenever empty.
- Reset, synchronous: wp=0, count=0, overflow=0, underflow=0, top=0. Array contents are don't-care and need not be cleared.
- Per-edge operation by {push,pop}:
  - 00: hold.
  - 10, not full: mem[wp] <= push_addr; wp++; count++.
  - 10, full: see Optional Feature; overflow <= 1.
  - 01, not empty: wp--; count--.
  - 01, empty: no state change; underflow <= 1.
  - 11, not empty: replace top: mem[wp-1] <= push_addr; wp and count unchanged. This is a tail call.
  - 11, empty: behaves as push (10); no underflow.
- Pointer arithmetic wraps modulo DEPTH.
- count saturates at DEPTH and never goes below 0.
- overflow and underflow stay set until reset; no other clear path.
- reset has priority over push and pop in the same cycle.
- push/pop are level-sampled every edge. The decoder guarantees single-cycle strobes per instruction; no edge detection is done here.

Optional Feature:
Macro: RSTACK_CIRCULAR_EN
- Defined: push when full overwrites the oldest entry.
  - mem[wp] <= push_addr; wp++; count stays DEPTH.
  - overflow is still set.
  - The most recent DEPTH return addresses remain correct.
- Undefined: push when full is dropped. Array, wp and count are unchanged; overflow is set; top keeps the old value.

Test Plan:
1. Reset, then push 0x010, 0x020, 0x030 on consecutive cycles -> count=3, top=0x030, empty=0, full=0; three pops -> top 0x020, 0x010, 0x000, then empty=1.
2. Pop while empty after reset -> underflow=1, count=0, top=0. underflow stays 1 through 5 idle cycles; reset clears it.
3. Push/pop same cycle with top=0x055, push_addr=0x07F -> top=0x07F, count unchanged. Same stimulus with empty stack -> count=1, top=0x07F, underflow=0.
4. DEPTH=8: push 0x001..0x008 -> full=1; push 0x009 -> overflow=1, count=8.
   - Without RSTACK_CIRCULAR_EN: top=0x008; 8 pops return 0x008..0x001.
   - With RSTACK_CIRCULAR_EN: top=0x009; 8 pops return 0x009..0x002.
5. Push 0x123 and 0x456, then assert reset together with push=1 -> next cycle count=0, empty=1, top=0, flags 0.
6. Integration with PC stage: BSR at PC=0x040 pushes 0x041; subroutine RET asserts pop -> PC loads 0x041 on the same edge, and stack count returns to its prior value.

Source files
------------

// File: rtl/return_stack_module.sv
// return_stack_module: return-address stack feeding the PC stage; RSTACK_CIRCULAR_EN makes push-when-full overwrite the oldest entry
module return_stack_module #(
  parameter int ADDR_W = 11,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);
  localparam int PW = $clog2(DEPTH);
`ifdef RSTACK_CIRCULAR_EN
  localparam bit CIRC = 1'b1;
`else
  localparam bit CIRC = 1'b0;
`endif
  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, tp;
  logic rep, wr, dn;
  assign tp = wp - PW'(1);
  assign empty = count == '0;
  assign full = count == CNT_W'(DEPTH);
  assign top = empty ? '0 : mem[tp];
  assign rep = push & pop & ~empty;
  assign wr = push & ~rep & (~full | CIRC);
  assign dn = pop & ~push & ~empty;
  // array writes: tail call replaces the top, normal push fills the slot at wp
  always_ff @(posedge clk) begin
    if (!reset && rep) mem[tp] <= push_addr;
    else if (!reset && wr) mem[wp] <= push_addr;
  end
  // pointer, occupancy and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr) wp <= wp + PW'(1);
      else if (dn) wp <= tp;
      if (wr && !full) count <= count + CNT_W'(1);
      else if (dn) count <= count - CNT_W'(1);
      if (push && !pop && full) overflow <= 1'b1;
      if (pop && !push && empty) underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_return_stack_module.sv
// tb_return_stack_module: directed checks of push/pop, tail call, overflow, underflow and reset priority
module tb_return_stack_module;
  logic clk = 0, reset = 0, push = 0, pop = 0;
  logic [10:0] push_addr = 0, top, pc_load;
  logic [3:0] count;
  logic empty, full, overflow, underflow;
  int errors = 0, checks = 0;
`ifdef RSTACK_CIRCULAR_EN
  localparam bit CIRC = 1'b1;
`else
  localparam bit CIRC = 1'b0;
`endif

  return_stack_module dut (.clk(clk), .reset(reset), .push(push), .pop(pop), .push_addr(push_addr),
    .top(top), .count(count), .empty(empty), .full(full), .overflow(overflow), .underflow(underflow));

  always #5 clk = ~clk;

  task automatic drive(input logic p, input logic q, input logic [10:0] a);
    push = p; pop = q; push_addr = a;
    @(posedge clk); #1;
    push = 0; pop = 0;
  endtask

  task automatic do_reset(input logic p);
    reset = 1; push = p; push_addr = 11'h7AA;
    @(posedge clk); #1;
    reset = 0; push = 0;
  endtask

  task automatic test_reset;
    do_reset(0);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (top !== 11'h000) begin errors++; $display("FAIL reset_top got=%h exp=000", top); end
    checks++; if ({empty, full, overflow, underflow} !== 4'b1000) begin errors++; $display("FAIL reset_flags got=%b exp=1000", {empty, full, overflow, underflow}); end
  endtask

  task automatic test_push_pop;
    do_reset(0);
    drive(1, 0, 11'h010); drive(1, 0, 11'h020); drive(1, 0, 11'h030);
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL pp_count got=%0d exp=3", count); end
    checks++; if (top !== 11'h030) begin errors++; $display("FAIL pp_top got=%h exp=030", top); end
    checks++; if ({empty, full} !== 2'b00) begin errors++; $display("FAIL pp_flags got=%b exp=00", {empty, full}); end
    drive(0, 1, 0);
    checks++; if (top !== 11'h020) begin errors++; $display("FAIL pop1_top got=%h exp=020", top); end
    drive(0, 1, 0);
    checks++; if (top !== 11'h010) begin errors++; $display("FAIL pop2_top got=%h exp=010", top); end
    drive(0, 1, 0);
    checks++; if (top !== 11'h000) begin errors++; $display("FAIL pop3_top got=%h exp=000", top); end
    checks++; if ({empty, count, underflow} !== {1'b1, 4'd0, 1'b0}) begin errors++; $display("FAIL pop3_state got=%b/%0d/%b exp=1/0/0", empty, count, underflow); end
  endtask

  task automatic test_underflow;
    do_reset(0);
    drive(0, 1, 0);
    checks++; if ({underflow, count, top} !== {1'b1, 4'd0, 11'h000}) begin errors++; $display("FAIL uf_set got=%b/%0d/%h exp=1/0/000", underflow, count, top); end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0);
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky%0d got=%b exp=1", i, underflow); end
    end
    do_reset(0);
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear got=%b exp=0", underflow); end
  endtask

  task automatic test_tail_call;
    do_reset(0);
    drive(1, 0, 11'h011); drive(1, 0, 11'h055);
    drive(1, 1, 11'h07F);
    checks++; if ({top, count} !== {11'h07F, 4'd2}) begin errors++; $display("FAIL tc_replace got=%h/%0d exp=07f/2", top, count); end
    drive(0, 1, 0);
    checks++; if (top !== 11'h011) begin errors++; $display("FAIL tc_below got=%h exp=011", top); end
    do_reset(0);
    drive(1, 1, 11'h07F);
    checks++; if ({top, count, underflow} !== {11'h07F, 4'd1, 1'b0}) begin errors++; $display("FAIL tc_empty got=%h/%0d/%b exp=07f/1/0", top, count, underflow); end
  endtask

  task automatic test_overflow;
    logic [10:0] exp;
    do_reset(0);
    for (int i = 1; i <= 8; i++) drive(1, 0, 11'(i));
    checks++; if ({full, overflow, count} !== {1'b1, 1'b0, 4'd8}) begin errors++; $display("FAIL ov_full got=%b/%b/%0d exp=1/0/8", full, overflow, count); end
    drive(1, 0, 11'h009);
    exp = CIRC ? 11'h009 : 11'h008;
    checks++; if ({overflow, count, top} !== {1'b1, 4'd8, exp}) begin errors++; $display("FAIL ov_push got=%b/%0d/%h exp=1/8/%h", overflow, count, top, exp); end
    for (int k = 0; k < 8; k++) begin
      exp = CIRC ? 11'(9 - k) : 11'(8 - k);
      checks++; if (top !== exp) begin errors++; $display("FAIL ov_pop%0d got=%h exp=%h", k, top, exp); end
      drive(0, 1, 0);
    end
    checks++; if ({empty, underflow, overflow} !== 3'b101) begin errors++; $display("FAIL ov_drain got=%b exp=101", {empty, underflow, overflow}); end
  endtask

  task automatic test_reset_priority;
    do_reset(0);
    drive(0, 1, 0);
    drive(1, 0, 11'h123); drive(1, 0, 11'h456);
    do_reset(1);
    checks++; if ({count, empty, top} !== {4'd0, 1'b1, 11'h000}) begin errors++; $display("FAIL rp_state got=%0d/%b/%h exp=0/1/000", count, empty, top); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL rp_flags got=%b exp=00", {overflow, underflow}); end
  endtask

  task automatic test_pc_integration;
    do_reset(0);
    drive(1, 0, 11'h200);
    drive(1, 0, 11'h041);
    push = 0; pop = 1; #1;
    pc_load = top;
    @(posedge clk); #1; pop = 0;
    checks++; if (pc_load !== 11'h041) begin errors++; $display("FAIL pc_load got=%h exp=041", pc_load); end
    checks++; if ({count, top} !== {4'd1, 11'h200}) begin errors++; $display("FAIL pc_after got=%0d/%h exp=1/200", count, top); end
  endtask

  initial begin
    #1;
    test_reset;
    test_push_pop;
    test_underflow;
    test_tail_call;
    test_overflow;
    test_reset_priority;
    test_pc_integration;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
